// File: rtl/pixel_write_buffer_pkg.sv
// pixel_pkg: shared screen geometry, FSM states and FIFO entry layout for the pixel write buffer
package pixel_pkg;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int ADDR_W = 17;
  localparam int COLOR_W = 12;
  localparam int LAST_ADDR = SCREEN_W * SCREEN_H - 1;
  typedef enum logic [1:0] {S_PASS, S_DRAIN, S_CLEAR} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [COLOR_W-1:0] color;
  } pix_entry_t;
endpackage

// File: rtl/pixel_write_buffer_if.sv
// pixel_write_buffer_if: frame-buffer write port, valid/ready handshake
interface pixel_write_buffer_if;
  import pixel_pkg::*;
  logic [ADDR_W-1:0] mem_addr;
  logic [COLOR_W-1:0] mem_data;
  logic mem_we;
  logic mem_ready;
  modport master(output mem_addr, output mem_data, output mem_we, input mem_ready);
  modport slave(input mem_addr, input mem_data, input mem_we, output mem_ready);
endinterface

// File: rtl/pixel_write_buffer_fifo.sv
// pixel_fifo: synchronous FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle
module pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 29
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata = mem[rp];
  always_ff @(posedge clk) if (do_push) mem[wp] <= wdata;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/pixel_write_buffer.sv
// pixel_write_buffer: buffers view-stage pixels, maps X/Y to linear addresses and writes video memory; full-screen clear FSM.
// Optional PIXEL_WRITE_BUFFER_DROP_COUNT_EN adds a saturating drop_count of FIFO-full drops.
module pixel_write_buffer
  import pixel_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int SCREEN_W = pixel_pkg::SCREEN_W,
  parameter int SCREEN_H = pixel_pkg::SCREEN_H,
  parameter int ADDR_W = pixel_pkg::ADDR_W
) (
  input  logic clk,
  input  logic resetn,
  input  logic [8:0] in_x,
  input  logic [7:0] in_y,
  input  logic [COLOR_W-1:0] in_color,
  input  logic in_we,
  input  logic clear_req,
  input  logic [COLOR_W-1:0] clear_color,
  pixel_write_buffer_if.master mem,
  output logic idle,
  output logic overflow,
  output logic clear_done
`ifdef PIXEL_WRITE_BUFFER_DROP_COUNT_EN
  ,
  output logic [15:0] drop_count
`endif
);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [COLOR_W-1:0] color;
  } entry_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SCREEN_W * SCREEN_H - 1);
  entry_t wr_e, rd_e;
  state_t state;
  logic [ADDR_W-1:0] cnt;
  logic [COLOR_W-1:0] fill;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic in_ok, full, empty, pop, drop, xfer, load, last_xfer;
  assign in_ok = in_we && 32'(in_x) < SCREEN_W && 32'(in_y) < SCREEN_H;
  assign wr_e = '{addr: ADDR_W'(in_y) * ADDR_W'(SCREEN_W) + ADDR_W'(in_x), color: in_color};
  assign xfer = mem.mem_we && mem.mem_ready;
  assign load = !mem.mem_we || xfer;
  assign last_xfer = xfer && state == S_CLEAR && mem.mem_addr == LAST;
  // the FIFO is held during a clear, except on its final beat so throughput stays 1/cycle
  assign pop = load && !empty && (state != S_CLEAR || last_xfer);
  assign drop = in_ok && full && !pop;
  assign idle = count == '0 && !mem.mem_we && state == S_PASS;
  pixel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(entry_t))) u_fifo (
    .clk(clk),
    .resetn(resetn),
    .push(in_ok),
    .pop(pop),
    .wdata(wr_e),
    .rdata(rd_e),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= S_PASS;
      cnt <= '0;
      fill <= '0;
      mem.mem_addr <= '0;
      mem.mem_data <= '0;
      mem.mem_we <= 1'b0;
      overflow <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= last_xfer;
      if (drop) overflow <= 1'b1;
      if (state == S_PASS && clear_req) begin
        fill <= clear_color;
        state <= S_DRAIN;
      end
      if (state == S_DRAIN && load && empty) state <= S_CLEAR;
      if (last_xfer) begin
        state <= S_PASS;
        cnt <= '0;
      end
      if (load && state == S_CLEAR && !last_xfer) begin
        mem.mem_addr <= cnt;
        mem.mem_data <= fill;
        mem.mem_we <= 1'b1;
        cnt <= cnt + ADDR_W'(1);
      end else if (load) begin
        mem.mem_we <= !empty;
        if (!empty) begin
          mem.mem_addr <= rd_e.addr;
          mem.mem_data <= rd_e.color;
        end
      end
    end
`ifdef PIXEL_WRITE_BUFFER_DROP_COUNT_EN
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) drop_count <= '0;
    else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
`endif
endmodule

// File: tb/tb_pixel_write_buffer.sv
// tb_pixel_write_buffer: scoreboard bench; expected writes queued at stimulus time, a negedge monitor checks every transfer
module tb_pixel_write_buffer;
  import pixel_pkg::*;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [8:0] in_x = '0;
  logic [7:0] in_y = '0;
  logic [11:0] in_color = '0;
  logic in_we = 1'b0;
  logic clear_req = 1'b0;
  logic [11:0] clear_color = '0;
  logic idle, overflow, clear_done;
`ifdef PIXEL_WRITE_BUFFER_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif
  pixel_write_buffer_if mif();
  pixel_write_buffer dut (
    .clk(clk),
    .resetn(resetn),
    .in_x(in_x),
    .in_y(in_y),
    .in_color(in_color),
    .in_we(in_we),
    .clear_req(clear_req),
    .clear_color(clear_color),
    .mem(mif.master),
    .idle(idle),
    .overflow(overflow),
    .clear_done(clear_done)
`ifdef PIXEL_WRITE_BUFFER_DROP_COUNT_EN
    ,
    .drop_count(drop_count)
`endif
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic last;
    logic [16:0] addr;
    logic [11:0] data;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cap = 1000;
  int done_cnt = 0;
  bit exp_done = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    resetn = 1'b0;
    in_we = 1'b0;
    clear_req = 1'b0;
    mif.mem_ready = 1'b0;
    sb.delete();
    exp_done = 0;
    done_cnt = 0;
    #1;
    check("rst_we", mif.mem_we, 0);
    check("rst_addr", mif.mem_addr, 0);
    check("rst_data", mif.mem_data, 0);
    check("rst_idle", idle, 1);
    check("rst_ovf", overflow, 0);
    check("rst_done", clear_done, 0);
    repeat (2) cyc;
    resetn = 1'b1;
    cyc;
  endtask
  task automatic pix(input int x, input int y, input int c);
    in_x = 9'(x);
    in_y = 8'(y);
    in_color = 12'(c);
    in_we = 1'b1;
    if (x < SCREEN_W && y < SCREEN_H && sb.size() < cap)
      sb.push_back('{1'b0, 17'(y * SCREEN_W + x), 12'(c)});
    cyc;
    in_we = 1'b0;
  endtask
  task automatic push_clear(input int c);
    for (int a = 0; a <= LAST_ADDR; a++) sb.push_back('{a == LAST_ADDR, 17'(a), 12'(c)});
  endtask
  task automatic wait_empty(input string name, input int budget);
    for (int t = 0; t < budget && sb.size() != 0; t++) cyc;
    check(name, sb.size(), 0);
  endtask
  always @(negedge clk)
    if (resetn) begin
      exp_t e;
      check("clear_done", clear_done, exp_done);
      if (clear_done) done_cnt++;
      exp_done = 0;
      if (mif.mem_we && mif.mem_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%0h required=none", mif.mem_addr);
        end else begin
          e = sb.pop_front();
          check("wr_addr", mif.mem_addr, e.addr);
          check("wr_data", mif.mem_data, e.data);
          exp_done = e.last;
        end
      end
    end
  initial begin
    mif.mem_ready = 1'b0;
    do_reset;
    mif.mem_ready = 1'b1;
    pix(5, 2, 12'hF00);
    check("lat_early_we", mif.mem_we, 0);
    cyc;
    check("lat_we", mif.mem_we, 1);
    check("lat_addr", mif.mem_addr, 645);
    check("lat_data", mif.mem_data, 12'hF00);
    cyc;
    check("lat_one_cycle", mif.mem_we, 0);
    pix(320, 10, 12'h123);
    pix(0, 240, 12'h456);
    repeat (3) begin
      check("range_we", mif.mem_we, 0);
      check("range_ovf", overflow, 0);
      check("range_idle", idle, 1);
      cyc;
    end
    do_reset;
    cap = FIFO_TOTAL();
    for (int i = 0; i < 18; i++) pix($urandom_range(319), $urandom_range(239), $urandom_range(4095));
    check("ovf_set", overflow, 1);
`ifdef PIXEL_WRITE_BUFFER_DROP_COUNT_EN
    check("drop_count", drop_count, 1);
`endif
    repeat (3) begin
      check("stall_we", mif.mem_we, 1);
      check("stall_addr", mif.mem_addr, sb[0].addr);
      check("stall_data", mif.mem_data, sb[0].data);
      cyc;
    end
    cap = 1000;
    mif.mem_ready = 1'b1;
    wait_empty("stall_drain", 100);
    cyc;
    check("stall_idle", idle, 1);
    check("ovf_sticky", overflow, 1);
    do_reset;
    mif.mem_ready = 1'b1;
    pix(10, 0, 12'hABC);
    pix(319, 239, 12'h0F0);
    pix(0, 1, 12'h111);
    clear_color = 12'h00F;
    clear_req = 1'b1;
    push_clear(12'h00F);
    cyc;
    clear_req = 1'b0;
    for (int t = 0; t < 80000 && sb.size() != 0; t++) begin
      clear_req = t == 100;
      clear_color = 12'hFFF;
      cyc;
      clear_req = 1'b0;
    end
    check("clear_drain", sb.size(), 0);
    repeat (2) cyc;
    check("clear_done_cnt", done_cnt, 1);
    check("clear_idle", idle, 1);
    do_reset;
    mif.mem_ready = 1'b1;
    clear_color = 12'h0F0;
    clear_req = 1'b1;
    push_clear(12'h0F0);
    cyc;
    clear_req = 1'b0;
    for (int t = 0; t < 2000 && !(mif.mem_we && mif.mem_addr == 1000); t++) cyc;
    check("reach_1000", mif.mem_addr, 1000);
    do_reset;
    repeat (3) cyc;
    check("abort_no_done", done_cnt, 0);
    mif.mem_ready = 1'b1;
    clear_req = 1'b1;
    push_clear(12'h0F0);
    cyc;
    clear_req = 1'b0;
    for (int t = 0; t < 500 && sb.size() > LAST_ADDR + 1 - 50; t++) cyc;
    check("restart_progress", 32'(sb.size() <= LAST_ADDR + 1 - 50), 1);
    do_reset;
    for (int i = 0; i < 10; i++) begin
      mif.mem_ready = i[0];
      pix($urandom_range(319), $urandom_range(239), $urandom_range(4095));
    end
    for (int t = 0; t < 100 && sb.size() != 0; t++) begin
      mif.mem_ready = ~mif.mem_ready;
      cyc;
    end
    check("toggle_drain", sb.size(), 0);
    do_reset;
    for (int i = 0; i < 400; i++) begin
      mif.mem_ready = $urandom_range(3) != 0;
      if ($urandom_range(2) != 0 && sb.size() < 10)
        pix($urandom_range(335), $urandom_range(250), $urandom_range(4095));
      else
        cyc;
    end
    mif.mem_ready = 1'b1;
    wait_empty("rand_drain", 100);
    cyc;
    check("rand_idle", idle, 1);
    check("rand_ovf", overflow, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  function automatic int FIFO_TOTAL();
    return 17;
  endfunction
endmodule

// File: doc/pixel_write_buffer.md
Name: pixel_write_buffer

Overview:
- Downstream of the game-view pixel generator; consumes its per-pixel (X, Y, colour, write-enable) stream.
- Buffers pixels in a small FIFO and converts X/Y to a linear frame-buffer address (Y*320+X).
- Drives the video-memory write port under a valid/ready handshake.
- Provides a full-screen clear sequence, so the game FSM can wipe the frame without a background pass.

Parameters:
- FIFO_DEPTH, 16, pixel FIFO entries (power of two, >=2)
- SCREEN_W, 320, visible width in pixels
- SCREEN_H, 240, visible height in pixels
- ADDR_W, 17, frame-buffer address width (must hold SCREEN_W*SCREEN_H-1)

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- in_x  in  9  pixel X from the view stage
- in_y  in  8  pixel Y from the view stage
- in_color  in  12  pixel colour, RGB444
- in_we  in  1  pixel valid, one pixel per cycle
- clear_req  in  1  single-cycle pulse: clear the whole screen
- clear_color  in  12  fill colour, sampled on the accepted clear_req
- mem_addr  out  ADDR_W  frame-buffer write address
- mem_data  out  12  frame-buffer write data
- mem_we  out  1  write valid
- mem_ready  in  1  memory accepts the write this cycle
- idle  out  1  FIFO empty, no pending write, FSM in S_PASS
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full
- clear_done  out  1  one-cycle pulse when the clear completes

Behaviour:
- Reset (asynchronous, resetn=0):
  - FIFO empty; output register empty.
  - mem_we=0, mem_addr=0, mem_data=0.
  - overflow=0, clear_done=0, idle=1.
  - FSM=S_PASS; clear counter=0.
  - Reset mid-clear abandons the clear; no clear_done is generated.
- Input filter: a pixel is pushed only if in_we=1, in_x<SCREEN_W and in_y<SCREEN_H. Out-of-range pixels are silently discarded and do not set overflow.
- Address computation: address = (in_y<<8)+(in_y<<6)+in_x, computed at push time, unsigned, zero-extended to ADDR_W. The FIFO stores {addr, color}.
- Push legality: a push is accepted when count<FIFO_DEPTH, or when count==FIFO_DEPTH and a pop occurs in the same cycle. Otherwise the pixel is dropped and overflow is set. overflow is cleared only by reset.
- Output stage:
  - A single register drives mem_addr/mem_data/mem_we.
  - A transfer occurs when mem_we && mem_ready.
  - The register loads from the FIFO when it is empty, or when it is being transferred in the same cycle.
  - mem_addr/mem_data hold stable while mem_we=1 and mem_ready=0.
- Latency and throughput: a pixel presented at edge N appears on mem_* after edge N+2 when the FIFO is empty and mem_ready=1. Sustained throughput is 1 pixel/cycle.
- FSM:
  - S_PASS: normal drain. A clear_req here latches clear_color and moves to S_DRAIN. clear_req in any other state is ignored.
  - S_DRAIN: inputs are still accepted. The FIFO keeps draining and the FSM waits until the FIFO is empty and the output register is empty or transferring, then moves to S_CLEAR. Pixels pushed during S_DRAIN are written before the clear and are therefore overwritten.
  - S_CLEAR: the output register carries {counter, latched colour}; the counter advances on each transfer. On transfer of address SCREEN_W*SCREEN_H-1 (76799): clear_done=1 for one cycle, counter returns to 0, FSM returns to S_PASS. The FIFO is not popped in this state; inputs are still accepted and are written after the clear.
- Simultaneous events:
  - clear_req and in_we in the same cycle: the pixel is pushed and drained before the clear.
  - Push and pop in the same cycle: count is unchanged.
- idle is combinational from the registered state.

Optional Feature:
- Macro: PIXEL_WRITE_BUFFER_DROP_COUNT_EN.
- Defined: adds output drop_count[15:0], which counts FIFO-full drops (not range drops). It saturates at 16'hFFFF and resets to 0.
- Undefined: no port and no counter logic; overflow flag only.

Decomposition:
- Shared package pixel_pkg:
  - constants SCREEN_W, SCREEN_H, ADDR_W, COLOR_W=12;
  - LAST_ADDR = SCREEN_W*SCREEN_H-1;
  - typedef for the FSM state enum {S_PASS, S_DRAIN, S_CLEAR};
  - typedef for the packed FIFO entry {addr, color}.
- One sub-module, pixel_fifo: synchronous FIFO with parameterised depth and width, push/pop/full/empty/count, and same-cycle push+pop when full.

Test Plan:
1. Reset, then push x=5,y=2,color=12'hF00 with mem_ready=1 -> after edge N+2, mem_we=1, mem_addr=645, mem_data=12'hF00, for one cycle.
2. Push x=320,y=10 and x=0,y=240 -> no mem_we, overflow stays 0, idle stays 1.
3. Hold mem_ready=0 and push 18 in-range pixels back-to-back (FIFO 16 + output reg 1) -> overflow=1 after the 18th; with DROP_COUNT_EN, drop_count=1; release mem_ready -> exactly 17 writes in push order, addresses stable while stalled.
4. Push 3 pixels, then clear_req with clear_color=12'h00F on the next cycle -> the 3 pixel writes occur first; then 76800 writes with addresses 0..76799 and data 12'h00F; clear_done pulses once on the last transfer; idle=1 afterwards.
5. Assert resetn=0 at clear address 1000 -> outputs return to reset values immediately; no clear_done; a new clear_req restarts at address 0.
6. Toggle mem_ready 1/0 every cycle during a 10-pixel burst -> exactly 10 transfers, in order, none duplicated or lost.
